// File: rtl/xillybus_axi_ram.sv
// AXI3 burst responder over a block RAM, standing in for the PS memory port
// behind the Xillybus DMA master. One transaction at a time, INCR/FIXED, byte strobes.
module xillybus_axi_ram #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR = '0
) (
  input  logic                            bus_clk,
  input  logic                            bus_rst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [3:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awcache,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [1:0]                      s_axi_bresp,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [3:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic [2:0]                      s_axi_arprot,
  input  logic [3:0]                      s_axi_arcache,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int RW = C_RAM_ADDR_WIDTH;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  // WRAP and reserved bursts (burst[1] set) are errors on every beat
  function automatic logic beat_err(input logic [AW-1:0] a, input logic [1:0] burst);
    logic [AW-1:0] off;
    off = a - C_BASEADDR;
    return burst[1] | (a < C_BASEADDR) | (|(off >> (RW + 3)));
  endfunction

  function automatic logic [RW-1:0] word_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - C_BASEADDR;
    return off[RW+2:3];
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + AW'(8) : a;
  endfunction

  logic [63:0] mem [1<<RW];

  state_t        state_q, state_d;
  logic          lwr_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    len_q;
  logic [1:0]    burst_q;
  logic [4:0]    beat_q;
  logic          werr_q;
  logic [1:0]    bresp_q;
  logic [63:0]   ram_dout_q;
  logic          p1_vld_q, p1_err_q, p1_last_q;
  logic          rvalid_q, rlast_q;
  logic [63:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          sk_vld_q, sk_err_q, sk_last_q;
  logic [63:0]   sk_data_q;

  logic          idle, aw_hs, ar_hs, w_hs, r_pop, w_err, w_last_beat, w_bad;
  logic          rd_issue, iss_err, iss_last;
  logic [AW-1:0] iss_addr;
  logic [1:0]    iss_burst, occ_next;
  logic [63:0]   p1_data;

  assign idle          = (state_q == IDLE) && !bus_rst;
  assign s_axi_awready = idle && s_axi_awvalid && (!s_axi_arvalid || lwr_q);
  assign s_axi_arready = idle && s_axi_arvalid && !s_axi_awready;
  assign s_axi_wready  = (state_q == WRITE);
  assign s_axi_bvalid  = (state_q == WRESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign r_pop       = rvalid_q && s_axi_rready;
  assign w_err       = beat_err(addr_q, burst_q);
  assign w_last_beat = (beat_q[3:0] == len_q);
  assign w_bad       = w_err || (s_axi_wlast != w_last_beat);

  // Entries held in output+skid after this edge; a new issue needs one free slot
  // even if rready stays low next cycle.
  assign occ_next  = {1'b0, rvalid_q} + {1'b0, sk_vld_q} + {1'b0, p1_vld_q} - {1'b0, r_pop};
  assign rd_issue  = ar_hs || ((state_q == READ) && (beat_q <= {1'b0, len_q}) && (occ_next <= 2'd1));
  assign iss_addr  = ar_hs ? s_axi_araddr : addr_q;
  assign iss_burst = ar_hs ? s_axi_arburst : burst_q;
  assign iss_err   = beat_err(iss_addr, iss_burst);
  assign iss_last  = ar_hs ? (s_axi_arlen == 4'd0) : (beat_q[3:0] == len_q);
  assign p1_data   = p1_err_q ? 64'd0 : ram_dout_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = WRITE; else if (ar_hs) state_d = READ;
      WRITE:   if (w_hs && w_last_beat) state_d = WRESP;
      WRESP:   if (s_axi_bready) state_d = IDLE;
      READ:    if (r_pop && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q <= IDLE;  lwr_q   <= 1'b1;  addr_q   <= '0;    len_q    <= '0;
      burst_q <= '0;    beat_q  <= '0;    werr_q   <= 1'b0;  bresp_q  <= OKAY;
      p1_vld_q <= 1'b0; p1_err_q <= 1'b0; p1_last_q <= 1'b0;
      rvalid_q <= 1'b0; rdata_q <= '0;    rresp_q  <= OKAY;  rlast_q  <= 1'b0;
      sk_vld_q <= 1'b0; sk_err_q <= 1'b0; sk_last_q <= 1'b0; sk_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        addr_q <= s_axi_awaddr; len_q <= s_axi_awlen; burst_q <= s_axi_awburst;
        beat_q <= '0; werr_q <= 1'b0; lwr_q <= 1'b0;
      end
      if (ar_hs) begin
        addr_q <= next_addr(s_axi_araddr, s_axi_arburst); len_q <= s_axi_arlen;
        burst_q <= s_axi_arburst; beat_q <= 5'd1; lwr_q <= 1'b1;
      end else if (rd_issue) begin
        addr_q <= next_addr(addr_q, burst_q); beat_q <= beat_q + 5'd1;
      end
      if (w_hs) begin
        addr_q <= next_addr(addr_q, burst_q);
        beat_q <= beat_q + 5'd1;
        werr_q <= werr_q || w_bad;
        if (w_last_beat) bresp_q <= (werr_q || w_bad) ? SLVERR : OKAY;
      end
      p1_vld_q  <= rd_issue;
      p1_err_q  <= iss_err;
      p1_last_q <= iss_last;
      if (!rvalid_q || r_pop) begin
        if (sk_vld_q) begin
          rvalid_q <= 1'b1; rdata_q <= sk_data_q; rlast_q <= sk_last_q;
          rresp_q  <= sk_err_q ? SLVERR : OKAY;
          sk_vld_q <= p1_vld_q; sk_data_q <= p1_data; sk_err_q <= p1_err_q; sk_last_q <= p1_last_q;
        end else if (p1_vld_q) begin
          rvalid_q <= 1'b1; rdata_q <= p1_data; rlast_q <= p1_last_q;
          rresp_q  <= p1_err_q ? SLVERR : OKAY;
        end else begin
          rvalid_q <= 1'b0; rlast_q <= 1'b0;
        end
      end else if (p1_vld_q) begin
        sk_vld_q <= 1'b1; sk_data_q <= p1_data; sk_err_q <= p1_err_q; sk_last_q <= p1_last_q;
      end
    end
  end

  // RAM is deliberately outside reset so contents survive a mid-burst abort.
  always_ff @(posedge bus_clk) begin
    if (w_hs && !w_err)
      for (int b = 0; b < 8; b++)
        if (s_axi_wstrb[b]) mem[word_idx(addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    ram_dout_q <= mem[word_idx(iss_addr)];
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awsize, s_axi_awprot, s_axi_awcache,
                       s_axi_arsize, s_axi_arprot, s_axi_arcache};
endmodule

// File: doc/xillybus_axi_ram.md
# xillybus_axi_ram

AXI3 burst responder backed by on-chip block RAM. It terminates the Xillybus core's 64-bit DMA master port (AR/R/AW/W/B channels, 4-bit burst length, no IDs) in place of the PS memory port, so the core's DMA engine can run standalone in simulation and hardware bring-up. It serves one transaction at a time, accepts INCR and FIXED bursts, and honours byte strobes.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 64, data width; only 64 is supported.
- C_RAM_ADDR_WIDTH, 10, log2 of RAM depth in 64-bit words.
- C_BASEADDR, 32'h00000000, byte address of RAM word 0; must be 8-byte aligned.
- bus_clk  in  1  sole clock; every port is synchronous to it.
- bus_rst  in  1  synchronous, active-high reset.
- s_axi_awvalid/awready  in/out  1/1  write-address handshake.
- s_axi_awaddr, awlen, awsize, awburst, awprot, awcache  in  32,4,3,2,3,4  write burst descriptor. awsize, awprot and awcache are ignored.
- s_axi_wvalid/wready  in/out  1/1  write-data handshake.
- s_axi_wdata, wstrb, wlast  in  64,8,1  write beat.
- s_axi_bvalid/bready  out/in  1/1  write-response handshake.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_arvalid/arready  in/out  1/1  read-address handshake.
- s_axi_araddr, arlen, arsize, arburst, arprot, arcache  in  32,4,3,2,3,4  read burst descriptor. arsize, arprot and arcache are ignored.
- s_axi_rvalid/rready  out/in  1/1  read-data handshake.
- s_axi_rdata, rresp, rlast  out  64,2,1  read beat.

## Operation
- States: IDLE, WRITE, WRESP, READ.
- Arbitration in IDLE (ready signals are combinational from the valids):
  - awready = awvalid & (!arvalid | last_was_read).
  - arready = arvalid & !awready.
  - last_was_read toggles according to the channel granted; its reset value is 1, so the first collision goes to write.
- Beat addressing:
  - Word index = (addr - C_BASEADDR) >> 3; addr[2:0] is ignored.
  - INCR adds 8 bytes per beat. FIXED keeps the same address for every beat.
  - WRAP (2'b10) and reserved (2'b11) bursts run their full beat count but perform no RAM writes; every beat is flagged as an error.
- Error flagging: a beat is an error if its word index is at or beyond 2^C_RAM_ADDR_WIDTH, or if addr < C_BASEADDR.
- Beat count is always awlen+1 or arlen+1. The address is a 32-bit sum and wraps modulo 2^32.
- WRITE:
  - wready = 1 throughout the state.
  - On each W handshake the RAM byte lanes selected by wstrb are written, unless the beat is an error.
  - After beat awlen+1 the block moves to WRESP. wlast does not end the burst.
  - bresp = SLVERR if any beat was an error, or if wlast differed from (beat == awlen) on any beat. Otherwise bresp = OKAY.
- WRESP: bvalid is held with bresp stable until bready; the block returns to IDLE the cycle after the handshake.
- READ:
  - The RAM has a 1-cycle synchronous read; an output register plus a one-entry skid buffer sustain 1 beat per cycle.
  - Per beat, rresp = SLVERR for an error beat and OKAY otherwise. Error beats return rdata = 0.
  - rlast = 1 on beat arlen+1 only. After the rlast handshake the block returns to IDLE.
- Reset mid-transaction: the burst is abandoned and no B or R response is issued. RAM contents are not cleared.

## Timing
- Reset values:
  - awready, wready, bvalid, arready, rvalid, rlast = 0.
  - bresp = 2'b00, rresp = 2'b00, rdata = 0.
  - state = IDLE.
  - These values are valid from the cycle after bus_rst is sampled high, and while it stays high.
- AW handshake at cycle T: wready = 1 from T+1. The last W handshake at cycle L gives bvalid = 1 at L+1.
- AR handshake at cycle T: first rvalid = 1 at T+2. With rready held high, beat k is presented at T+1+k.
- rready low: rvalid, rdata, rresp and rlast hold stable and no beat is lost. Throughput returns to 1 beat per cycle once rready goes high.
- Read-after-write ordering: a read granted after a write's B handshake returns the newly written data.
- IDLE is re-entered 1 cycle after the final handshake, so the earliest next AW/AR grant is that cycle.

## Test plan
- Write then read back:
  - Stimulus: write to addr 0x100 with awlen=3, INCR, wstrb=FF, data 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Then read 0x100 with arlen=3.
  - Required: bresp=OKAY, bvalid at L+1; 4 matching beats with rlast on beat 4 only and rresp=OKAY.
- Byte strobes:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to 0x0 with wstrb=FF, then write 0 to 0x0 with wstrb=0x0F.
  - Required: a read of 0x0 returns 0xFFFF_FFFF_0000_0000.
- FIXED burst: write awlen=2 to 0x40 with data A, B, C -> word 8 holds C and word 9 is unchanged.
- Out of range (C_RAM_ADDR_WIDTH=10):
  - Stimulus: read 0x1FF8 with arlen=1 (INCR).
  - Required: beat 1 = RAM word 1023 with rresp=OKAY; beat 2 rdata=0 with rresp=SLVERR. A write to 0x2000 returns bresp=SLVERR and RAM is unchanged.
- Collision and backpressure:
  - Stimulus: awvalid and arvalid asserted together from reset; rready toggled 1,0,0,1 during the read.
  - Required: write is granted first and read second; rdata stays stable while rready=0; all beats arrive in order.
- Reset mid-burst: bus_rst asserted after write beat 2 of 4 -> the next cycle has all outputs at reset values and no B response; beats 1–2 remain in RAM.
